// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX sampler, the TX side and the baud-generator math.
package uart_pkg;

   localparam int c_OVERSAMPLE = 3;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_state_t;

endpackage

// File: rtl/uart_rx_3x_sampler_if.sv
// Byte-level output bus from the UART receiver toward the RX FIFO.
interface uart_rx_3x_sampler_if #(
   parameter int c_DATABITS = 8
);
   logic [c_DATABITS-1:0] o_data;
   logic                  o_write;
   logic                  o_frame_error;
   logic                  o_overrun;
   logic                  o_busy;
   logic                  i_full;

   modport master (
      output o_data, o_write, o_frame_error, o_overrun, o_busy,
      input  i_full
   );

   modport slave (
      input  o_data, o_write, o_frame_error, o_overrun, o_busy,
      output i_full
   );
endinterface

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for asynchronous single-bit inputs, with a selectable reset value.
module sync_ff #(
   parameter int   c_STAGES    = 2,
   parameter logic c_RESET_VAL = 1'b0
) (
   input  logic i_clock,
   input  logic i_resetn,
   input  logic i_d,
   output logic o_q
);

   logic [c_STAGES-1:0] stage_q;

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         stage_q <= {c_STAGES{c_RESET_VAL}};
      end else begin
         stage_q <= {stage_q[c_STAGES-2:0], i_d};
      end
   end

   assign o_q = stage_q[c_STAGES-1];

endmodule

// File: rtl/uart_rx_3x_sampler.sv
// 8N1 UART receiver front end: 3x oversampled on i_tick, emits each byte as a one-cycle FIFO write.
//
//   state | meaning
//   IDLE  | line idle, waiting for a low sample
//   START | low seen; next tick confirms or rejects the start bit
//   DATA  | sampling data bits mid-bit, LSB first
//   STOP  | waiting for the stop-bit sample
//   BREAK | stop bit was low; wait for the line to go high
module uart_rx_3x_sampler
   import uart_pkg::*;
#(
   parameter int c_DATABITS   = 8,
   parameter int c_SYNCSTAGES = 2
) (
   input  logic                  i_clock,
   input  logic                  i_resetn,
   input  logic                  i_tick,
   input  logic                  i_rx,
   uart_rx_3x_sampler_if.master  bus
);

   localparam int               c_BITW     = $clog2(c_DATABITS);
   localparam logic [1:0]       c_PH_LAST  = 2'(c_OVERSAMPLE - 1);
   localparam logic [c_BITW-1:0] c_BIT_LAST = c_BITW'(c_DATABITS - 1);

   uart_state_t            state_q;
   logic [1:0]             phase_q;
   logic [c_BITW-1:0]      bit_q;
   logic [c_DATABITS-1:0]  shift_q;
   logic [c_DATABITS-1:0]  data_q;
   logic                   write_q;
   logic                   frame_err_q;
   logic                   overrun_q;
   logic                   rx_s;

   sync_ff #(
      .c_STAGES    (c_SYNCSTAGES),
      .c_RESET_VAL (1'b1)
   ) u_sync_rx (
      .i_clock  (i_clock),
      .i_resetn (i_resetn),
      .i_d      (i_rx),
      .o_q      (rx_s)
   );

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         state_q     <= IDLE;
         phase_q     <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         write_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         write_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         if (i_tick) begin
            case (state_q)
               IDLE: begin
                  if (!rx_s) begin
                     state_q <= START;
                     phase_q <= '0;
                  end
               end
               START: begin
                  if (rx_s) begin
                     state_q <= IDLE;
                  end else begin
                     state_q <= DATA;
                     phase_q <= '0;
                     bit_q   <= '0;
                  end
               end
               DATA: begin
                  // Sampling on the wrap keeps each sample one full bit after the mid-start sample.
                  if (phase_q == c_PH_LAST) begin
                     phase_q <= '0;
                     shift_q <= {rx_s, shift_q[c_DATABITS-1:1]};
                     if (bit_q == c_BIT_LAST) begin
                        state_q <= STOP;
                     end else begin
                        bit_q <= bit_q + 1'b1;
                     end
                  end else begin
                     phase_q <= phase_q + 1'b1;
                  end
               end
               STOP: begin
                  if (phase_q == c_PH_LAST) begin
                     phase_q <= '0;
                     if (!rx_s) begin
                        frame_err_q <= 1'b1;
                        state_q     <= BREAK;
                     end else begin
                        state_q <= IDLE;
                        if (bus.i_full) begin
                           overrun_q <= 1'b1;
                        end else begin
                           write_q <= 1'b1;
                           data_q  <= shift_q;
                        end
                     end
                  end else begin
                     phase_q <= phase_q + 1'b1;
                  end
               end
               BREAK: begin
                  if (rx_s) begin
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.o_data        = data_q;
   assign bus.o_write       = write_q;
   assign bus.o_frame_error = frame_err_q;
   assign bus.o_overrun     = overrun_q;
   assign bus.o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_3x_sampler.sv
// Directed bench for uart_rx_3x_sampler: ticks every 16 clocks, so one bit time is 48 clocks.
module tb_uart_rx_3x_sampler;

   localparam int c_BIT = 48;

   logic i_clock  = 1'b0;
   logic i_resetn = 1'b0;
   logic i_tick   = 1'b0;
   logic i_rx     = 1'b1;
   int   tick_div = 0;

   int n_checks = 0;
   int n_pass   = 0;

   int         wr_cnt    = 0;
   int         fe_cnt    = 0;
   int         ov_cnt    = 0;
   int         busy_cnt  = 0;
   int         multi_cnt = 0;
   logic [7:0] wr_q[$];

   uart_rx_3x_sampler_if #(.c_DATABITS(8)) bus ();

   uart_rx_3x_sampler #(
      .c_DATABITS   (8),
      .c_SYNCSTAGES (2)
   ) dut (
      .i_clock  (i_clock),
      .i_resetn (i_resetn),
      .i_tick   (i_tick),
      .i_rx     (i_rx),
      .bus      (bus)
   );

   always #5 i_clock = ~i_clock;

   always @(negedge i_clock) begin
      tick_div = (tick_div == 15) ? 0 : tick_div + 1;
      i_tick   = (tick_div == 0);
   end

   always @(negedge i_clock) begin
      if (i_resetn) begin
         if (bus.o_write === 1'b1) begin
            wr_cnt++;
            wr_q.push_back(bus.o_data);
         end
         if (bus.o_frame_error === 1'b1) fe_cnt++;
         if (bus.o_overrun === 1'b1) ov_cnt++;
         if (bus.o_busy === 1'b1) busy_cnt++;
         if ((32'(bus.o_write) + 32'(bus.o_frame_error) + 32'(bus.o_overrun)) > 1) multi_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic clr_counts();
      @(posedge i_clock);
      wr_cnt   = 0;
      fe_cnt   = 0;
      ov_cnt   = 0;
      busy_cnt = 0;
      wr_q.delete();
      @(negedge i_clock);
   endtask

   // Called at a falling edge; returns at a falling edge.
   task automatic drive_rx(input logic v, input int n_clk);
      i_rx = v;
      repeat (n_clk) @(negedge i_clock);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_bits);
      drive_rx(1'b0, c_BIT);
      for (int i = 0; i < 8; i++) drive_rx(b[i], c_BIT);
      drive_rx(stop_v, c_BIT * stop_bits);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 600; i++) begin
         if (bus.o_busy === 1'b0) break;
         @(negedge i_clock);
      end
      check(tag, 32'(bus.o_busy), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_full = 1'b0;
      repeat (5) @(negedge i_clock);
      i_resetn = 1'b1;
      repeat (5) @(negedge i_clock);
      check("rst_data",  32'(bus.o_data),        32'h00);
      check("rst_write", 32'(bus.o_write),       32'd0);
      check("rst_ferr",  32'(bus.o_frame_error), 32'd0);
      check("rst_ovr",   32'(bus.o_overrun),     32'd0);
      check("rst_busy",  32'(bus.o_busy),        32'd0);

      // single byte
      clr_counts();
      send_frame(8'hA5, 1'b1, 1);
      drive_rx(1'b1, c_BIT);
      wait_idle("a5_busy");
      check("a5_wr_cnt", 32'(wr_cnt), 32'd1);
      check("a5_data",   32'(bus.o_data), 32'hA5);
      check("a5_fe_cnt", 32'(fe_cnt), 32'd0);
      check("a5_ov_cnt", 32'(ov_cnt), 32'd0);

      // back-to-back frames, no idle gap
      clr_counts();
      send_frame(8'h00, 1'b1, 1);
      send_frame(8'hFF, 1'b1, 1);
      send_frame(8'h55, 1'b1, 1);
      drive_rx(1'b1, c_BIT);
      wait_idle("b2b_busy");
      check("b2b_wr_cnt", 32'(wr_cnt), 32'd3);
      check("b2b_byte0",  32'(wr_q[0]), 32'h00);
      check("b2b_byte1",  32'(wr_q[1]), 32'hFF);
      check("b2b_byte2",  32'(wr_q[2]), 32'h55);
      check("b2b_fe_cnt", 32'(fe_cnt), 32'd0);

      // 16-clock glitch covers exactly one tick: START rejects it one tick later
      clr_counts();
      drive_rx(1'b0, 16);
      drive_rx(1'b1, 100);
      check("glitch_busy_cycles", 32'(busy_cnt), 32'd16);
      check("glitch_wr_cnt", 32'(wr_cnt), 32'd0);
      check("glitch_fe_cnt", 32'(fe_cnt), 32'd0);
      check("glitch_ov_cnt", 32'(ov_cnt), 32'd0);
      check("glitch_busy",   32'(bus.o_busy), 32'd0);

      // stop bit held low for 20 bit times
      clr_counts();
      send_frame(8'h3C, 1'b0, 20);
      check("brk_busy_low_line", 32'(bus.o_busy), 32'd1);
      check("brk_fe_cnt", 32'(fe_cnt), 32'd1);
      check("brk_wr_cnt", 32'(wr_cnt), 32'd0);
      drive_rx(1'b1, c_BIT);
      wait_idle("brk_busy_release");
      send_frame(8'h81, 1'b1, 1);
      drive_rx(1'b1, c_BIT);
      wait_idle("x81_busy");
      check("x81_wr_cnt", 32'(wr_cnt), 32'd1);
      check("x81_data",   32'(bus.o_data), 32'h81);
      check("x81_fe_cnt", 32'(fe_cnt), 32'd1);

      // FIFO full at the stop tick
      clr_counts();
      bus.i_full = 1'b1;
      send_frame(8'h7E, 1'b1, 1);
      bus.i_full = 1'b0;
      drive_rx(1'b1, c_BIT);
      wait_idle("ovr_busy");
      check("ovr_ov_cnt", 32'(ov_cnt), 32'd1);
      check("ovr_wr_cnt", 32'(wr_cnt), 32'd0);
      check("ovr_data",   32'(bus.o_data), 32'h81);

      // reset mid-frame, during bit 4 of 0xC3
      clr_counts();
      drive_rx(1'b0, c_BIT);
      for (int i = 0; i < 4; i++) drive_rx(1'(8'hC3 >> i), c_BIT);
      drive_rx(1'b0, 24);
      #2 i_resetn = 1'b0;
      #1;
      check("mid_rst_data",  32'(bus.o_data),        32'h00);
      check("mid_rst_write", 32'(bus.o_write),       32'd0);
      check("mid_rst_ferr",  32'(bus.o_frame_error), 32'd0);
      check("mid_rst_ovr",   32'(bus.o_overrun),     32'd0);
      check("mid_rst_busy",  32'(bus.o_busy),        32'd0);
      @(negedge i_clock);
      @(negedge i_clock);
      i_resetn = 1'b1;
      drive_rx(1'b0, 22);
      for (int i = 5; i < 8; i++) drive_rx(1'(8'hC3 >> i), c_BIT);
      drive_rx(1'b1, c_BIT);
      drive_rx(1'b1, c_BIT * 12);
      wait_idle("post_rst_idle");
      clr_counts();
      send_frame(8'h42, 1'b1, 1);
      drive_rx(1'b1, c_BIT);
      wait_idle("x42_busy");
      check("x42_wr_cnt", 32'(wr_cnt), 32'd1);
      check("x42_data",   32'(bus.o_data), 32'h42);
      check("x42_fe_cnt", 32'(fe_cnt), 32'd0);

      check("pulse_exclusive", 32'(multi_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
